// File: rtl/float8_pack_unpack.sv
// rtl/float8_pack_unpack.sv - registered FP32->FP8 (RNE, saturating) and FP8->FP32 converters
module float8_pack_unpack #(
   parameter int E  = 4,
   parameter int M  = 3,
   parameter bit FN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] f32_i,
   output logic [7:0]  fp8_o,
   output logic        sat_o,
   input  logic [7:0]  fp8_in,
   output logic [31:0] f32_out
);
   localparam int BIAS     = (1 << (E - 1)) - 1;
   localparam int MAX_CODE = FN ? (1 << (E + M)) - 2 : (((1 << E) - 1) << M) - 1;
   localparam logic [6:0]   MAX_BITS = 7'(MAX_CODE);
   localparam logic [6:0]   NAN_BITS = 7'h7F;
   localparam logic [6:0]   INF_BITS = 7'(((1 << E) - 1) << M);
   localparam logic [E-1:0] EXP_ONES = '1;
   localparam logic [M-1:0] MAN_ONES = '1;
   localparam logic [22-M:0] ZPAD    = '0;

   logic              p_sign;
   logic [7:0]        p_exp;
   logic [22:0]       p_man;
   logic signed [9:0] biased;
   logic [4:0]        shift;
   logic [55:0]       aligned;
   logic [M:0]        kept;
   logic              guard;
   logic              sticky;
   logic              round_up;
   logic [15:0]       code_unr;
   logic [15:0]       code_rnd;
   logic [6:0]        pack_mag;
   logic              pack_sat;

   assign p_sign = f32_i[31];
   assign p_exp  = f32_i[30:23];
   assign p_man  = f32_i[22:0];

   // Normal and subnormal targets share one aligner: subnormals shift further right,
   // and a rounding carry naturally walks into the exponent field.
   always_comb begin
      biased = $signed({2'b00, p_exp}) - 10'sd127 + 10'(BIAS);
      if (biased >= 10'sd1)
         shift = 5'd0;
      else if (biased < -10'sd29)
         shift = 5'd31;
      else
         shift = 5'(10'sd1 - biased);
      aligned  = {1'b1, p_man, 32'd0} >> shift;
      kept     = aligned[55 -: M + 1];
      guard    = aligned[54 - M];
      sticky   = |aligned[53 - M:0];
      round_up = guard & (sticky | kept[0]);
      code_unr = (biased >= 10'sd1) ? (16'(biased - 1) << M) + 16'(kept) : 16'(kept);
      code_rnd = code_unr + 16'(round_up);

      pack_mag = 7'd0;
      pack_sat = 1'b0;
      if (p_exp == 8'hFF) begin
         if (p_man != 23'd0) begin
            pack_mag = NAN_BITS;
         end else begin
            pack_mag = FN ? MAX_BITS : INF_BITS;
            pack_sat = 1'b1;
         end
      end else if (p_exp != 8'h00) begin
         if (code_rnd > 16'(MAX_CODE)) begin
            pack_mag = MAX_BITS;
            pack_sat = 1'b1;
         end else begin
            pack_mag = code_rnd[6:0];
         end
      end
   end

   logic          u_sign;
   logic [E-1:0]  u_exp;
   logic [M-1:0]  u_man;
   int            lead;
   logic [M-1:0]  u_norm;
   logic [31:0]   unpack_res;

   assign u_sign = fp8_in[7];
   assign u_exp  = fp8_in[6:M];
   assign u_man  = fp8_in[M-1:0];

   always_comb begin
      lead = 0;
      for (int i = 0; i < M; i++)
         if (u_man[i]) lead = i;
      // Shifting out the leading one leaves the fraction left-aligned.
      u_norm = u_man << (M - lead);

      unpack_res = {u_sign, 31'd0};
      if (u_exp == EXP_ONES && (FN ? (u_man == MAN_ONES) : (u_man != '0)))
         unpack_res = {u_sign, 31'h7FC00000};
      else if (!FN && u_exp == EXP_ONES)
         unpack_res = {u_sign, 8'hFF, 23'd0};
      else if (u_exp == '0) begin
         if (u_man != '0)
            unpack_res = {u_sign, 8'(128 - BIAS - (M - lead)), u_norm, ZPAD};
      end else
         unpack_res = {u_sign, 8'(int'(u_exp) - BIAS + 127), u_man, ZPAD};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fp8_o   <= 8'd0;
         sat_o   <= 1'b0;
         f32_out <= 32'd0;
      end else begin
         fp8_o   <= {p_sign, pack_mag};
         sat_o   <= pack_sat;
         f32_out <= unpack_res;
      end
   end
endmodule

// File: tb/tb_float8_pack_unpack.sv
// tb/tb_float8_pack_unpack.sv - self-checking bench for float8_pack_unpack (E4M3 FN)
module tb_float8_pack_unpack;
   localparam int M    = 3;
   localparam int BIAS = 7;
   localparam int MAXC = 126;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] f32_i = 32'd0;
   logic [7:0]  fp8_o;
   logic        sat_o;
   logic [7:0]  fp8_in = 8'd0;
   logic [31:0] f32_out;

   int passed = 0;
   int total  = 0;

   float8_pack_unpack dut (
      .clk     (clk),
      .rst     (rst),
      .f32_i   (f32_i),
      .fp8_o   (fp8_o),
      .sat_o   (sat_o),
      .fp8_in  (fp8_in),
      .f32_out (f32_out)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic real pow2(input int n);
      real r;
      r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else        for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   // Magnitude of a 7-bit FP8 pattern, read as if every exponent were finite.
   function automatic real fp8_val(input int c);
      int ex;
      int m;
      real rm;
      ex = c >> M;
      m  = c % (1 << M);
      if (ex == 0) begin
         rm = m;
         return rm * pow2(1 - BIAS - M);
      end
      rm = (1 << M) + m;
      return rm * pow2(ex - BIAS - M);
   endfunction

   // Returns {sat, fp8}: nearest code by real distance, ties to the even code.
   function automatic logic [8:0] pack_ref(input logic [31:0] f);
      logic s;
      int   ef;
      int   mf;
      real  mag, d, bestd, rm;
      int   best;
      s  = f[31];
      ef = int'(f[30:23]);
      mf = int'(f[22:0]);
      if (ef == 255) return (mf != 0) ? {1'b0, s, 7'h7F} : {1'b1, s, 7'(MAXC)};
      if (ef == 0) return {1'b0, s, 7'd0};
      rm  = mf;
      mag = (8388608.0 + rm) * pow2(ef - 150);
      if (mag >= fp8_val(MAXC + 1)) return {1'b1, s, 7'(MAXC)};
      best  = 0;
      bestd = mag;
      for (int c = 1; c <= MAXC + 1; c++) begin
         d = mag - fp8_val(c);
         if (d < 0.0) d = -d;
         if (d < bestd || (d == bestd && (c % 2) == 0)) begin
            best  = c;
            bestd = d;
         end
      end
      if (best > MAXC) return {1'b1, s, 7'(MAXC)};
      return {1'b0, s, 7'(best)};
   endfunction

   function automatic logic [31:0] unpack_ref(input logic [7:0] c);
      real v;
      int  e;
      int  mant;
      if (c[6:0] == 7'h7F) return {c[7], 31'h7FC00000};
      v = fp8_val(int'(c[6:0]));
      if (v == 0.0) return {c[7], 31'd0};
      e = 0;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0)  begin v = v * 2.0; e--; end
      mant = $rtoi((v - 1.0) * 8388608.0);
      return {c[7], 8'(e + 127), 23'(mant)};
   endfunction

   function automatic logic [31:0] rand_f32();
      logic [31:0] f;
      int mode;
      mode = $urandom_range(0, 3);
      f    = $urandom;
      if (mode != 0) f[30:23] = 8'($urandom_range(105, 140));
      if (mode == 3) f[18:0] = 19'd0;
      return f;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         f32_i  = $urandom;
         fp8_in = 8'($urandom);
         tick();
         total++;
         if ({sat_o, fp8_o, f32_out} !== 41'd0)
            $display("FAIL reset[%0d]: sat=%0b fp8=%h f32=%h, want all zero", i, sat_o, fp8_o, f32_out);
         else passed++;
      end
      rst    = 1'b0;
      f32_i  = 32'h3F800000;
      fp8_in = 8'h38;
      tick();
      total++;
      if ({sat_o, fp8_o, f32_out} !== {1'b0, 8'h38, 32'h3F800000})
         $display("FAIL first_after_reset: sat=%0b fp8=%h f32=%h, want 0 38 3f800000", sat_o, fp8_o, f32_out);
      else passed++;
   endtask

   task automatic test_pack_directed;
      logic [31:0] vin [15] = '{32'h3F800000, 32'hBF800000, 32'h43E00000, 32'h00000000, 32'h80000000,
                                32'h3F880000, 32'h3F980000, 32'h43E80000, 32'h43E88000, 32'h447A0000,
                                32'hFF800000, 32'h7FC00000, 32'h3B000000, 32'h3A800000, 32'h00000001};
      logic [8:0]  vexp [15] = '{9'h038, 9'h0B8, 9'h07E, 9'h000, 9'h080,
                                 9'h038, 9'h03A, 9'h07E, 9'h17E, 9'h17E,
                                 9'h1FE, 9'h07F, 9'h001, 9'h000, 9'h000};
      for (int i = 0; i < 15; i++) begin
         f32_i = vin[i];
         tick();
         total++;
         if ({sat_o, fp8_o} !== vexp[i])
            $display("FAIL pack_directed %h: got sat=%0b fp8=%h, want sat=%0b fp8=%h",
                     vin[i], sat_o, fp8_o, vexp[i][8], vexp[i][7:0]);
         else passed++;
      end
   endtask

   task automatic test_unpack_directed;
      logic [7:0]  vin [8]  = '{8'h38, 8'hB8, 8'h7E, 8'h01, 8'h04, 8'h80, 8'h7F, 8'hFF};
      logic [31:0] vexp [8] = '{32'h3F800000, 32'hBF800000, 32'h43E00000, 32'h3B000000,
                                32'h3C000000, 32'h80000000, 32'h7FC00000, 32'hFFC00000};
      for (int i = 0; i < 8; i++) begin
         fp8_in = vin[i];
         tick();
         total++;
         if (f32_out !== vexp[i])
            $display("FAIL unpack_directed %h: got %h, want %h", vin[i], f32_out, vexp[i]);
         else passed++;
      end
   endtask

   task automatic test_back_to_back;
      logic [8:0]  ep = 9'd0;
      logic [31:0] eu = 32'd0;
      for (int i = 0; i < 24; i++) begin
         f32_i  = rand_f32();
         fp8_in = 8'($urandom);
         #1;
         if (i > 0) begin
            total++;
            if ({sat_o, fp8_o, f32_out} !== {ep, eu})
               $display("FAIL hold[%0d]: got %h %h, want %h %h", i, {sat_o, fp8_o}, f32_out, ep, eu);
            else passed++;
         end
         ep = pack_ref(f32_i);
         eu = unpack_ref(fp8_in);
         tick();
         total++;
         if ({sat_o, fp8_o, f32_out} !== {ep, eu})
            $display("FAIL back_to_back[%0d]: got %h %h, want %h %h", i, {sat_o, fp8_o}, f32_out, ep, eu);
         else passed++;
      end
   endtask

   task automatic test_mid_reset;
      f32_i = 32'h447A0000;
      fp8_in = 8'h7E;
      rst   = 1'b1;
      tick();
      total++;
      if ({sat_o, fp8_o, f32_out} !== 41'd0)
         $display("FAIL mid_reset: got sat=%0b fp8=%h f32=%h, want zero", sat_o, fp8_o, f32_out);
      else passed++;
      rst    = 1'b0;
      f32_i  = 32'hBF800000;
      fp8_in = 8'h01;
      tick();
      total++;
      if ({sat_o, fp8_o, f32_out} !== {1'b0, 8'hB8, 32'h3B000000})
         $display("FAIL mid_reset_resume: got %h %h, want 0b8 3b000000", {sat_o, fp8_o}, f32_out);
      else passed++;
   endtask

   task automatic test_roundtrip;
      logic [31:0] rt;
      logic [8:0]  ep;
      for (int c = 0; c < 256; c++) begin
         fp8_in = 8'(c);
         tick();
         rt = f32_out;
         total++;
         if (rt !== unpack_ref(8'(c)))
            $display("FAIL roundtrip_unpack %h: got %h, want %h", c, rt, unpack_ref(8'(c)));
         else passed++;
         f32_i = rt;
         ep = (c[6:0] == 7'h7F) ? {1'b0, c[7], 7'h7F} : {1'b0, 8'(c)};
         tick();
         total++;
         if ({sat_o, fp8_o} !== ep)
            $display("FAIL roundtrip_pack %h: got sat=%0b fp8=%h, want sat=%0b fp8=%h",
                     c, sat_o, fp8_o, ep[8], ep[7:0]);
         else passed++;
      end
   endtask

   task automatic test_random;
      logic [8:0]  ep;
      logic [31:0] eu;
      for (int i = 0; i < 1500; i++) begin
         f32_i  = rand_f32();
         fp8_in = 8'($urandom);
         ep = pack_ref(f32_i);
         eu = unpack_ref(fp8_in);
         tick();
         total++;
         if ({sat_o, fp8_o} !== ep)
            $display("FAIL random_pack %h: got sat=%0b fp8=%h, want sat=%0b fp8=%h",
                     f32_i, sat_o, fp8_o, ep[8], ep[7:0]);
         else passed++;
         total++;
         if (f32_out !== eu)
            $display("FAIL random_unpack %h: got %h, want %h", fp8_in, f32_out, eu);
         else passed++;
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_pack_directed();
      test_unpack_directed();
      test_back_to_back();
      test_mid_reset();
      test_roundtrip();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
